// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared constants, fetch FSM state type and PC helpers used by
//             the instruction-fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // Instruction word presented to decode for a bubble
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;

    // Width of one instruction in bytes; sequential fetch step
    localparam logic [31:0] INST_BYTES = 32'd4;

    // Fetch control state: RUN streams instructions, STALL waits for release
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } fetch_state_t;

    // Sequential successor of a fetch address (32-bit wrap)
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

    // Force a redirect target onto an instruction boundary
    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Bundle of the fetch stage's control inputs, instruction-memory
//             port and IF/ID outputs. The fetch stage uses the master view,
//             the surrounding pipeline/memory uses the slave view.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  mem_inst,
        output mem_pc,
        output id_pc,
        output id_inst,
        output id_valid
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_target,
        output mem_inst,
        input  mem_pc,
        input  id_pc,
        input  id_inst,
        input  id_valid
    );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch + IF/ID register. Drives the fetch address to
//             a one-cycle-latency instruction memory, tracks which address is
//             in flight, and delivers {pc, inst, valid} to decode. A stall
//             destroys the in-flight word, so the fetch address is rewound to
//             it and replayed on release. Redirects squash both younger slots.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic     clock,
    input  wire logic     reset,
    fetch_stage_if.master bus
);

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_valid_q, inflight_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;

    // Per-edge action selected by the control FSM (mutually exclusive)
    logic w_redirect;
    logic w_advance;
    logic w_rewind;
    logic w_replay;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect wins and lands in STALL if the hazard persists
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = bus.stall ? STALL : RUN;
        end else begin
            case (state_q)
                RUN:     if (bus.stall)  state_d = STALL;
                STALL:   if (!bus.stall) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // FSM outputs: decode the action to take at this edge
    always_comb begin
        w_redirect = bus.redirect_valid;
        w_advance  = 1'b0;
        w_rewind   = 1'b0;
        w_replay   = 1'b0;
        if (!bus.redirect_valid) begin
            case (state_q)
                RUN: begin
                    w_advance = !bus.stall;
                    w_rewind  = bus.stall;
                end
                STALL:   w_replay = !bus.stall;
                default: ;
            endcase
        end
    end

    // Datapath next values; anything not touched by the action holds
    always_comb begin
        pc_d             = pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = inflight_valid_q;
        id_pc_d          = id_pc_q;
        id_inst_d        = id_inst_q;
        id_valid_d       = id_valid_q;

        if (w_redirect) begin
            // Squash the in-flight fetch and the ID slot, restart at target
            pc_d             = pc_align(bus.redirect_target);
            inflight_valid_d = 1'b0;
            id_valid_d       = 1'b0;
            id_inst_d        = NOP_INST;
        end else if (w_advance) begin
            inflight_pc_d    = pc_q;
            inflight_valid_d = 1'b1;
            pc_d             = pc_next(pc_q);
            id_pc_d          = inflight_pc_q;
            id_inst_d        = inflight_valid_q ? bus.mem_inst : NOP_INST;
            id_valid_d       = inflight_valid_q;
        end else if (w_rewind) begin
            // The memory zeroed the word in flight: refetch it after release
            if (inflight_valid_q) begin
                pc_d = inflight_pc_q;
            end
            inflight_valid_d = 1'b0;
        end else if (w_replay) begin
            // Memory latches pc_q now; decode consumed the held instruction
            inflight_pc_d    = pc_q;
            inflight_valid_d = 1'b1;
            pc_d             = pc_next(pc_q);
            id_valid_d       = 1'b0;
            id_inst_d        = NOP_INST;
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            inflight_pc_q    <= 32'h0;
            inflight_valid_q <= 1'b0;
            id_pc_q          <= 32'h0;
            id_inst_q        <= NOP_INST;
            id_valid_q       <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
            id_pc_q          <= id_pc_d;
            id_inst_q        <= id_inst_d;
            id_valid_q       <= id_valid_d;
        end
    end

    assign bus.mem_pc   = pc_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_valid = id_valid_q;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage with an instruction memory
//             model and a queue-based model of the delivered ID stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic clock;
    logic reset;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(C_RESET_PC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: one-cycle read latency, output zero while stalled
    logic [31:0] imem [0:63];
    logic [31:0] mem_q;

    always @(posedge clock) begin
        mem_q <= bus.stall ? 32'h0 : imem[bus.mem_pc[7:2]];
    end
    assign bus.mem_inst = bus.stall ? 32'h0 : mem_q;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return imem[pc[7:2]];
    endfunction

    // ---------------------------------------------------------------------
    // Reference model of the ID stream.
    //   pend    : slots that will reach ID on the next run edges
    //             (bit 32 = real instruction, [31:0] = its address)
    //   m_next  : next address the fetch will request (= mem_pc)
    //   m_stall : waiting for stall release
    // ---------------------------------------------------------------------
    logic [32:0] pend [$];
    logic [31:0] m_next;
    logic        m_stall;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_pc_known;
    logic [31:0] m_inst;

    int checks = 0;
    int errors = 0;

    task automatic model_edge(input logic rs, input logic st, input logic rv,
                              input logic [31:0] tgt);
        logic [32:0] e;
        if (rs) begin
            m_valid = 1'b0; m_inst = 32'h0; m_pc = 32'h0; m_pc_known = 1'b1;
            pend.delete(); pend.push_back(33'h0);
            m_next = C_RESET_PC; m_stall = 1'b0;
        end else if (rv) begin
            m_valid = 1'b0; m_inst = 32'h0;
            pend.delete(); pend.push_back(33'h0);
            m_next = {tgt[31:2], 2'b00}; m_stall = st;
        end else if (m_stall) begin
            if (!st) begin
                m_valid = 1'b0; m_inst = 32'h0;
                pend.delete(); pend.push_back({1'b1, m_next});
                m_next = m_next + 32'd4; m_stall = 1'b0;
            end
        end else if (st) begin
            if (pend.size() > 0 && pend[0][32]) m_next = pend[0][31:0];
            pend.delete();
            m_stall = 1'b1;
        end else begin
            e = (pend.size() > 0) ? pend.pop_front() : 33'h0;
            m_valid    = e[32];
            m_pc_known = e[32];
            if (e[32]) m_pc = e[31:0];
            m_inst = e[32] ? word_at(e[31:0]) : 32'h0;
            pend.push_back({1'b1, m_next});
            m_next = m_next + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        chk("id_valid", {31'h0, bus.id_valid}, {31'h0, m_valid});
        chk("id_inst",  bus.id_inst, m_inst);
        chk("mem_pc",   bus.mem_pc,  m_next);
        if (m_pc_known) chk("id_pc", bus.id_pc, m_pc);
    endtask

    // One clock: drive at negedge, model the edge, check 1 time unit later
    task automatic cycle(input logic rs, input logic st, input logic rv,
                         input logic [31:0] tgt);
        @(negedge clock);
        reset                = rs;
        bus.stall            = st;
        bus.redirect_valid   = rv;
        bus.redirect_target  = tgt;
        @(posedge clock);
        model_edge(rs, st, rv, tgt);
        #1;
        compare();
    endtask

    initial begin
        reset = 1'b1; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;
        m_next = C_RESET_PC; m_stall = 1'b0; m_valid = 1'b0;
        m_pc = 32'h0; m_pc_known = 1'b0; m_inst = 32'h0;
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[0] = 32'h0100_006F;   // jal  x0, 16
        imem[1] = 32'h0010_0093;   // addi x1, x0, 1
        imem[2] = 32'h0020_0113;   // addi x2, x0, 2
        imem[3] = 32'h0020_81B3;   // add  x3, x1, x2

        // Reset then free run: ID shows 0,4,8,12 from the second edge
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        chk("reset_id_pc", bus.id_pc, 32'h0);
        chk("reset_mem_pc", bus.mem_pc, C_RESET_PC);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);

        // Stall 3 cycles while id_pc = 4
        cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        chk("pre_stall_id_pc", bus.id_pc, 32'h4);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        chk("stall_hold_id_pc", bus.id_pc, 32'h4);
        cycle(0, 0, 0, 0);
        chk("stall_bubble", {31'h0, bus.id_valid}, 32'h0);
        cycle(0, 0, 0, 0);
        chk("stall_resume_id_pc", bus.id_pc, 32'h8);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

        // Redirect to 0x20 while id_pc = 0
        cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h20);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("redirect_target_id_pc", bus.id_pc, 32'h20);
        cycle(0, 0, 0, 0);
        chk("redirect_next_id_pc", bus.id_pc, 32'h24);

        // Misaligned redirect with stall high for 2 cycles
        cycle(0, 1, 1, 32'h13); cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("redir_stall_bubble", {31'h0, bus.id_valid}, 32'h0);
        cycle(0, 0, 0, 0);
        chk("redir_stall_id_pc", bus.id_pc, 32'h10);
        cycle(0, 0, 0, 0);

        // Back-to-back stall / release / re-stall
        cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

        // Randomized stall / redirect traffic
        for (int i = 0; i < 300; i++) begin
            logic st, rv;
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            cycle(0, st, rv, $urandom_range(0, 255));
        end

        // Reset asserted during STALL
        cycle(0, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("rst_stall_id_pc", bus.id_pc, 32'h0);
        chk("rst_stall_mem_pc", bus.mem_pc, C_RESET_PC);
        chk("rst_stall_id_inst", bus.id_inst, 32'h0);
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        chk("post_rst_first_id", bus.id_pc, 32'h0);
        cycle(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
